// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S DAC path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

    localparam int DEF_SAMPLE_WIDTH       = 24;
    localparam int DEF_SLOT_BITS          = 32;
    localparam int DEF_BCLK_HALF          = 8;
    localparam int DEF_UNDERRUN_CNT_WIDTH = 16;
    localparam int DEF_FRAME_BITS         = 2 * DEF_SLOT_BITS;

    // LRCK level doubles as the channel code: 0 = left, 1 = right.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    function automatic int frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: divides clk into BCLK, tracks frame bit position, drives LRCK.
// Latency: BCLK toggles every BCLK_HALF clks; first falling edge 2*BCLK_HALF clks after reset release.
// Backpressure: none, free-running.
// Ports: clk/reset (async active-low); i2s_bclk, i2s_lrck registered clocks;
//        fall_evt strobes in the clk before BCLK falls; bit_cnt_nxt is the frame bit that fall moves to.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BCLK_HALF = DEF_BCLK_HALF,
    parameter int CNT_W     = $clog2(frame_bits(DEF_SLOT_BITS))
) (
    input  logic             clk,
    input  logic             reset,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             fall_evt,
    output logic [CNT_W-1:0] bit_cnt_nxt
);

    localparam int FRAME_BITS = frame_bits(SLOT_BITS);
    localparam int DIV_W      = $clog2(BCLK_HALF);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             div_wrap;

    assign div_wrap    = (div_cnt == DIV_W'(BCLK_HALF - 1));
    assign fall_evt    = div_wrap & i2s_bclk;
    assign bit_cnt_nxt = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);

    // bit_cnt starts at the last bit so the first fall wraps to 0 and loads a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
            bit_cnt  <= CNT_W'(FRAME_BITS - 1);
            i2s_lrck <= 1'b1;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (fall_evt) begin
                bit_cnt  <= bit_cnt_nxt;
                i2s_lrck <= (bit_cnt_nxt >= CNT_W'(SLOT_BITS));
            end
        end
    end

endmodule

// File: rtl/i2s_dac_serializer.sv
// Stereo sample to I2S serializer with a one-pair holding register and underrun tracking.
// Latency: pair held until next frame load; left MSB on i2s_dat one BCLK after LRCK falls.
// Backpressure: sample_ready low while holding is full; an empty holding register at frame load is an underrun.
// Ports: clk, reset (async active-low); sample_left/right/valid/ready handshake;
//        i2s_bclk/i2s_lrck/i2s_dat to DAC; frame_start/underrun pulses; underrun_cnt saturating.
// Build option: define I2S_LEFT_JUSTIFIED_EN to drop the one-BCLK data delay (left-justified format).
module i2s_dac_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH       = DEF_SAMPLE_WIDTH,
    parameter int SLOT_BITS          = DEF_SLOT_BITS,
    parameter int BCLK_HALF          = DEF_BCLK_HALF,
    parameter int UNDERRUN_CNT_WIDTH = DEF_UNDERRUN_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SAMPLE_WIDTH-1:0]       sample_left,
    input  logic [SAMPLE_WIDTH-1:0]       sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          i2s_bclk,
    output logic                          i2s_lrck,
    output logic                          i2s_dat,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt
);

    localparam int CNT_W = $clog2(frame_bits(SLOT_BITS));

    logic                    fall_evt;
    logic [CNT_W-1:0]        bit_cnt_nxt;
    logic [SAMPLE_WIDTH-1:0] holding_l, holding_r;
    logic                    holding_full;
    logic [SAMPLE_WIDTH-1:0] frame_l, frame_r;
    logic [SAMPLE_WIDTH-1:0] frame_l_nxt, frame_r_nxt;
    logic                    full_nxt;
    logic                    accept;
    logic                    load;
    int                      slot_pos;
    int                      bit_idx;
    channel_e                ch_sel;
    logic [SAMPLE_WIDTH-1:0] ch_word;
    logic                    dat_nxt;

    i2s_clk_gen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_HALF (BCLK_HALF),
        .CNT_W     (CNT_W)
    ) u_clk_gen (
        .clk         (clk),
        .reset       (reset),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .fall_evt    (fall_evt),
        .bit_cnt_nxt (bit_cnt_nxt)
    );

    assign accept = sample_valid & sample_ready;
    assign load   = fall_evt & (bit_cnt_nxt == '0);

    // Load empties holding first; an accept in the same cycle refills it, so a
    // pair arriving on an underrun edge waits for the following frame.
    always_comb begin
        frame_l_nxt = frame_l;
        frame_r_nxt = frame_r;
        full_nxt    = holding_full;
        if (load) begin
            frame_l_nxt = holding_full ? holding_l : '0;
            frame_r_nxt = holding_full ? holding_r : '0;
            full_nxt    = 1'b0;
        end
        if (accept) begin
            full_nxt = 1'b1;
        end
    end

    // Bit select uses the post-load frame and post-fall bit position so the
    // registered i2s_dat lines up with the BCLK edge that is about to happen.
    always_comb begin
        slot_pos = int'(bit_cnt_nxt);
        ch_sel   = CH_LEFT;
        if (slot_pos >= SLOT_BITS) begin
            slot_pos = slot_pos - SLOT_BITS;
            ch_sel   = CH_RIGHT;
        end
        ch_word = (ch_sel == CH_LEFT) ? frame_l_nxt : frame_r_nxt;
`ifdef I2S_LEFT_JUSTIFIED_EN
        bit_idx = SAMPLE_WIDTH - 1 - slot_pos;
`else
        bit_idx = SAMPLE_WIDTH - slot_pos;
`endif
        // Out-of-range index (slot 0 delay bit, or past the sample) yields 0.
        dat_nxt = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (i == bit_idx) begin
                dat_nxt = ch_word[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holding_l    <= '0;
            holding_r    <= '0;
            holding_full <= 1'b0;
            frame_l      <= '0;
            frame_r      <= '0;
            sample_ready <= 1'b0;
            i2s_dat      <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            holding_full <= full_nxt;
            sample_ready <= ~full_nxt;
            if (accept) begin
                holding_l <= sample_left;
                holding_r <= sample_right;
            end
            frame_l     <= frame_l_nxt;
            frame_r     <= frame_r_nxt;
            frame_start <= load;
            underrun    <= load & ~holding_full;
            if (load && !holding_full && !(&underrun_cnt)) begin
                underrun_cnt <= underrun_cnt + UNDERRUN_CNT_WIDTH'(1);
            end
            if (fall_evt) begin
                i2s_dat <= dat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed bench for i2s_dac_serializer: reset, idle underruns, preload pattern,
// streaming handshake, same-cycle accept/underrun, and mid-frame reset.
// Outputs sampled 1 time unit after each rising clk edge.
module tb_i2s_dac_serializer;

    localparam int BIT_CLKS = 16;  // clk per BCLK period at default BCLK_HALF

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int LPOS = 40;
    localparam int RPOS = 8;
    localparam logic [63:0] EXP_PRE = 64'h80000100_7FFFFE00;
`else
    localparam int LPOS = 39;
    localparam int RPOS = 7;
    localparam logic [63:0] EXP_PRE = 64'h40000080_3FFFFF00;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_dat;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int dat_hi  = 0;
    int rdy_cnt = 0;
    int n_acc   = 0;
    bit stream_mode = 1'b0;
    int pair_idx = 0;
    int n_pairs  = 0;

    always #5 clk = ~clk;

    i2s_dac_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_dat      (i2s_dat),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] pl(input int p);
        return 24'h100000 + 24'(p);
    endfunction

    function automatic logic [23:0] pr(input int p);
        return 24'h200000 + 24'(p);
    endfunction

    // One clk; producer side advances when the handshake fired on that edge.
    task automatic step();
        logic acc;
        acc = sample_valid && sample_ready;
        @(posedge clk);
        #1;
        if (i2s_dat) dat_hi++;
        if (sample_ready) rdy_cnt++;
        if (acc) begin
            n_acc++;
            if (stream_mode) begin
                pair_idx++;
                if (pair_idx >= n_pairs) begin
                    sample_valid = 1'b0;
                end else begin
                    sample_left  = pl(pair_idx);
                    sample_right = pr(pair_idx);
                end
            end else begin
                sample_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_fs(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < limit);
        if (!frame_start) check("frame_start_timeout", 64'(n), 64'(limit + 1));
    endtask

    // Starts on a frame_start sample; returns 64 bits, slot 0 in bit 63.
    task automatic capture(output logic [63:0] s);
        s = '0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) repeat (BIT_CLKS) step();
            s = {s[62:0], i2s_dat};
            if (k == 0)  check("lrck_slot0", 64'(i2s_lrck), 64'd0);
            if (k == 32) check("lrck_slot32", 64'(i2s_lrck), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int a0;
        int r0;
        logic [63:0] s;

        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_bclk", 64'(i2s_bclk), 64'd0);
        check("rst_lrck", 64'(i2s_lrck), 64'd1);
        check("rst_dat", 64'(i2s_dat), 64'd0);
        check("rst_ready", 64'(sample_ready), 64'd0);
        check("rst_fs", 64'(frame_start), 64'd0);
        check("rst_ucnt", 64'(underrun_cnt), 64'd0);

        // Idle: underruns every frame
        reset = 1'b1;
        d0 = dat_hi;
        step();
        check("ready_after_release", 64'(sample_ready), 64'd1);
        wait_fs(100, n);
        check("first_fs_latency", 64'(n + 1), 64'd16);
        check("idle_ur1", 64'(underrun), 64'd1);
        check("idle_ucnt1", 64'(underrun_cnt), 64'd1);
        wait_fs(2000, n);
        check("fs_period", 64'(n), 64'd1024);
        check("idle_ur2", 64'(underrun), 64'd1);
        check("idle_ucnt2", 64'(underrun_cnt), 64'd2);
        wait_fs(2000, n);
        check("idle_ucnt3", 64'(underrun_cnt), 64'd3);
        check("idle_dat_zero", 64'(dat_hi - d0), 64'd0);

        // Preload pattern
        sample_left  = 24'h800001;
        sample_right = 24'h7FFFFE;
        sample_valid = 1'b1;
        wait_fs(2000, n);
        check("pre_no_ur", 64'(underrun), 64'd0);
        capture(s);
        check("pre_stream", s, EXP_PRE);

        // Streaming with valid held high
        stream_mode  = 1'b1;
        n_pairs      = 10;
        pair_idx     = 0;
        sample_left  = pl(0);
        sample_right = pr(0);
        sample_valid = 1'b1;
        for (int f = 0; f < 10; f++) begin
            wait_fs(100, n);
            check("strm_no_ur", 64'(underrun), 64'd0);
            check("strm_ready_at_load", 64'(sample_ready), 64'd1);
            a0 = n_acc;
            r0 = rdy_cnt;
            capture(s);
            check("strm_left", 64'(s[LPOS +: 24]), 64'(pl(f)));
            check("strm_right", 64'(s[RPOS +: 24]), 64'(pr(f)));
            check("strm_accepts", 64'(n_acc - a0), (f < 9) ? 64'd1 : 64'd0);
            if (f < 9) check("strm_ready_low", 64'(rdy_cnt - r0), 64'd0);
        end
        stream_mode = 1'b0;

        // Accept on the load edge with holding empty
        repeat (15) step();
        sample_left  = 24'hABCDEF;
        sample_right = 24'h123456;
        sample_valid = 1'b1;
        step();
        check("same_fs", 64'(frame_start), 64'd1);
        check("same_ur", 64'(underrun), 64'd1);
        check("same_ready", 64'(sample_ready), 64'd0);
        capture(s);
        check("same_zero_frame", s, 64'd0);
        wait_fs(100, n);
        check("same_next_no_ur", 64'(underrun), 64'd0);
        capture(s);
        check("same_left", 64'(s[LPOS +: 24]), 64'h00ABCDEF);
        check("same_right", 64'(s[RPOS +: 24]), 64'h00123456);

        // Mid-frame reset at bit 40
        sample_left  = 24'h000000;
        sample_right = 24'hFFFFFF;
        sample_valid = 1'b1;
        wait_fs(100, n);
        check("mid_no_ur", 64'(underrun), 64'd0);
        repeat (40 * BIT_CLKS + 10) step();
        check("mid_dat", 64'(i2s_dat), 64'd1);
        check("mid_bclk", 64'(i2s_bclk), 64'd1);
        check("mid_ready", 64'(sample_ready), 64'd1);
        check("mid_ucnt", 64'(underrun_cnt), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        check("mrst_bclk", 64'(i2s_bclk), 64'd0);
        check("mrst_lrck", 64'(i2s_lrck), 64'd1);
        check("mrst_dat", 64'(i2s_dat), 64'd0);
        check("mrst_ready", 64'(sample_ready), 64'd0);
        check("mrst_ucnt", 64'(underrun_cnt), 64'd0);
        reset = 1'b1;
        step();
        check("mrst_ucnt_after", 64'(underrun_cnt), 64'd0);
        wait_fs(100, n);
        check("mrst_fs_latency", 64'(n + 1), 64'd16);
        check("mrst_ucnt_first", 64'(underrun_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
